// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_pkg
//  Description : Shared register indices, FSM encoding and source map for
//                the int_ctrl interrupt controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

    localparam logic [1:0] REG_MASK = 2'd0;
    localparam logic [1:0] REG_PEND = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam int SRC_TC0 = 0;
    localparam int SRC_TC1 = 1;
    localparam int SRC_EXT = 2;

endpackage
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : int_prio_enc
//  Description : Combinational lowest-index-wins priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_prio_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Prioritised interrupt controller with edge/level capture,
//                masking and a REQ/ACK/EOI handshake to the CPU.
//                Define INT_CTRL_SYNC_EN to insert a 2-flop src synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 6,
    parameter int VEC_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic [1:0]         addr,
    input  logic               we,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               int_req,
    output logic [VEC_W-1:0]   int_vec,
    input  logic               int_ack,
    output logic               busy
);

    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] prev_q;
    state_e             state_q, state_d;
    logic               int_req_q, int_req_d;
    logic [VEC_W-1:0]   int_vec_q, int_vec_d;

    logic [NUM_SRC-1:0] w_src;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic               w_ack_fire;
    logic               w_eoi;
    logic [VEC_W-1:0]   w_enc_idx;
    logic               w_enc_valid;
    logic               w_unused_wdata;

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign w_src = sync2_q;
`else
    assign w_src = src;
`endif

    assign w_unused_wdata = ^wdata[31:NUM_SRC];

    int_prio_enc #(
        .N (NUM_SRC),
        .W (VEC_W)
    ) u_prio_enc (
        .req_i   (pend_q & mask_q),
        .idx_o   (w_enc_idx),
        .valid_o (w_enc_valid)
    );

    // Capture: edge sources set on a 0->1 transition, level sources every high cycle.
    always_comb begin
        w_set      = (mode_q & w_src & ~prev_q) | (~mode_q & w_src);
        w_w1c      = (we && (addr == REG_PEND)) ? wdata[NUM_SRC-1:0] : '0;
        w_eoi      = we && (addr == REG_STAT);
        w_ack_fire = (state_q == REQ) && int_ack;
        w_ack_clr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_ack_clr[i] = w_ack_fire && mode_q[i] && (int_vec_q == VEC_W'(i));
        end
        // OR-ing the set last lets a fresh capture beat a same-edge clear.
        pend_d = (pend_q & ~w_w1c & ~w_ack_clr) | w_set;
        mask_d = (we && (addr == REG_MASK)) ? wdata[NUM_SRC-1:0] : mask_q;
        mode_d = (we && (addr == REG_MODE)) ? wdata[NUM_SRC-1:0] : mode_q;
    end

    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        int_vec_d = int_vec_q;
        case (state_q)
            IDLE: begin
                if (w_enc_valid) begin
                    state_d   = REQ;
                    int_req_d = 1'b1;
                    int_vec_d = w_enc_idx;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d   = SERVICE;
                    int_req_d = 1'b0;
                end
            end
            SERVICE: begin
                if (w_eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            pend_q    <= '0;
            mode_q    <= '0;
            prev_q    <= '0;
            state_q   <= IDLE;
            int_req_q <= 1'b0;
            int_vec_q <= '0;
        end else begin
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            prev_q    <= w_src;
            state_q   <= state_d;
            int_req_q <= int_req_d;
            int_vec_q <= int_vec_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_MASK: rdata[NUM_SRC-1:0] = mask_q;
            REG_PEND: rdata[NUM_SRC-1:0] = pend_q;
            REG_MODE: rdata[NUM_SRC-1:0] = mode_q;
            default: begin
                rdata[9:8]       = state_q;
                rdata[VEC_W-1:0] = int_vec_q;
            end
        endcase
    end

    assign int_req = int_req_q;
    assign int_vec = int_vec_q;
    assign busy    = (state_q == REQ) || (state_q == SERVICE);

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Self-checking bench for int_ctrl: directed scenarios plus
//                randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam int NUM_SRC = 6;
    localparam int VEC_W   = 3;
`ifdef INT_CTRL_SYNC_EN
    localparam bit SYNC = 1'b1;
    localparam int LAT  = 2;
`else
    localparam bit SYNC = 1'b0;
    localparam int LAT  = 0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_SRC-1:0] src;
    logic [1:0]         addr;
    logic               we;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               int_req;
    logic [VEC_W-1:0]   int_vec;
    logic               int_ack;
    logic               busy;

    int total  = 0;
    int bad    = 0;
    bit cmp_en = 1'b0;

    int_ctrl #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .int_req (int_req),
        .int_vec (int_vec),
        .int_ack (int_ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [NUM_SRC-1:0] m_mask, m_pend, m_mode, m_prev, m_s1, m_s2;
    int               m_state;   // 0 idle, 1 offering, 2 servicing
    bit               m_req;
    int               m_vec;

    function automatic int lowest(input bit [NUM_SRC-1:0] v);
        for (int i = 0; i < NUM_SRC; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[NUM_SRC-1:0] = m_mask;
            2'd1: r[NUM_SRC-1:0] = m_pend;
            2'd2: r[NUM_SRC-1:0] = m_mode;
            default: begin
                r[9:8] = m_state[1:0];
                r[2:0] = m_vec[2:0];
            end
        endcase
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit [NUM_SRC-1:0] s, set, clr, nxt;
        if (reset) begin
            m_mask = '0; m_pend = '0; m_mode = '0; m_prev = '0;
            m_s1 = '0; m_s2 = '0; m_state = 0; m_req = 1'b0; m_vec = 0;
        end else begin
            s = SYNC ? m_s2 : src;
            if (SYNC) begin
                m_s2 = m_s1;
                m_s1 = src;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                set[i] = m_mode[i] ? (s[i] && !m_prev[i]) : s[i];
            end
            clr = '0;
            if (we && addr == 2'd1) clr = wdata[NUM_SRC-1:0];
            if (m_state == 1 && int_ack && m_mode[m_vec]) clr[m_vec] = 1'b1;
            nxt = (m_pend & ~clr) | set;
            case (m_state)
                0: if ((m_pend & m_mask) != 0) begin
                       m_vec = lowest(m_pend & m_mask); m_req = 1'b1; m_state = 1;
                   end
                1: if (int_ack) begin
                       m_req = 1'b0; m_state = 2;
                   end
                default: if (we && addr == 2'd3) m_state = 0;
            endcase
            m_pend = nxt;
            m_prev = s;
            if (we && addr == 2'd0) m_mask = wdata[NUM_SRC-1:0];
            if (we && addr == 2'd2) m_mode = wdata[NUM_SRC-1:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_int_req", {31'b0, int_req}, {31'b0, m_req});
            chk("cyc_int_vec", {29'b0, int_vec}, m_vec);
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_state != 0});
            chk("cyc_rdata", rdata, exp_rd(addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic chk_rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    initial begin
        reset = 1'b1; src = '0; addr = '0; we = 1'b0; wdata = '0; int_ack = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_req", {31'b0, int_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        for (int a = 0; a < 4; a++) chk_rd("rst_reg", 2'(a), 32'd0);

        // single edge pulse on source 1
        wr(2'd0, 32'h07);
        wr(2'd2, 32'h07);
        src = 6'b000010; tick(); src = '0;
        repeat (LAT) tick();
        chk_rd("t1_pend", 2'd1, 32'h02);
        chk("t1_model_pend", {26'b0, m_pend}, 32'h02);
        chk("t1_req_early", {31'b0, int_req}, 32'd0);
        tick();
        chk("t1_req", {31'b0, int_req}, 32'd1);
        chk("t1_vec", {29'b0, int_vec}, 32'd1);
        chk_rd("t1_stat", 2'd3, 32'h101);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk_rd("t1_pend_ack", 2'd1, 32'h00);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        chk("t1_req_ack", {31'b0, int_req}, 32'd0);
        wr(2'd3, 32'd0);
        chk("t1_busy_eoi", {31'b0, busy}, 32'd0);
        tick();
        chk("t1_no_req", {31'b0, int_req}, 32'd0);

        // simultaneous rise on sources 0 and 2
        src = 6'b000101; tick(); src = '0;
        repeat (LAT) tick();
        tick();
        chk("t2_req", {31'b0, int_req}, 32'd1);
        chk("t2_vec0", {29'b0, int_vec}, 32'd0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        wr(2'd3, 32'd0);
        chk("t2_req_gap", {31'b0, int_req}, 32'd0);
        tick();
        chk("t2_req2", {31'b0, int_req}, 32'd1);
        chk("t2_vec2", {29'b0, int_vec}, 32'd2);
        chk("t2_model_vec", m_vec, 32'd2);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        wr(2'd3, 32'd0);

        // masked capture, late unmask, W1C during REQ
        wr(2'd0, 32'h00);
        src = 6'b000001; tick(); src = '0;
        repeat (LAT) tick();
        chk_rd("t3_pend", 2'd1, 32'h01);
        tick();
        chk("t3_masked", {31'b0, int_req}, 32'd0);
        wr(2'd0, 32'h01);
        chk("t3_req_same", {31'b0, int_req}, 32'd0);
        tick();
        chk("t3_req", {31'b0, int_req}, 32'd1);
        wr(2'd1, 32'h01);
        chk("t3_req_held", {31'b0, int_req}, 32'd1);
        chk("t3_vec_held", {29'b0, int_vec}, 32'd0);
        chk_rd("t3_pend_clr", 2'd1, 32'h00);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        wr(2'd3, 32'd0);

        // level mode: W1C is overridden while the line stays high
        wr(2'd0, 32'h00);
        wr(2'd2, 32'h00);
        src = 6'b000010;
        repeat (LAT + 1) tick();
        wr(2'd1, 32'h02);
        chk_rd("t4_pend_held", 2'd1, 32'h02);
        src = '0;
        repeat (LAT) tick();
        wr(2'd1, 32'h02);
        chk_rd("t4_pend_clr", 2'd1, 32'h00);

        // reset while in SERVICE
        wr(2'd2, 32'h07);
        wr(2'd0, 32'h07);
        src = 6'b000001; tick(); src = '0;
        repeat (LAT) tick();
        tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t5_busy_svc", {31'b0, busy}, 32'd1);
        reset = 1'b1; tick();
        chk("t5_req", {31'b0, int_req}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        for (int a = 0; a < 4; a++) chk_rd("t5_reg", 2'(a), 32'd0);
        reset = 1'b0; tick();

        // ack and EOI in IDLE are ignored
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_req", {31'b0, int_req}, 32'd0);
        wr(2'd3, 32'd0);
        chk_rd("t6_stat", 2'd3, 32'd0);

        // randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 4000; n++) begin
            int r;
            if ($urandom_range(0, 3) == 0) src = {3'b000, 3'($urandom)};
            int_ack = ($urandom_range(0, 2) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 15);
            we = 1'b0;
            addr = 2'($urandom);
            wdata = $urandom;
            if (r == 0) begin
                addr = 2'd3; we = 1'b1;
            end else if (r <= 3) begin
                addr = 2'($urandom_range(0, 2)); we = 1'b1;
            end
            tick();
        end
        reset = 1'b0; we = 1'b0; int_ack = 1'b0; src = '0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Prioritised interrupt controller between the timer and external interrupt sources and the CPU's hardware-interrupt input.
- Latches edge- or level-type requests into a pending register, applies a mask, and raises a single request with an encoded vector.
- Sequences each interrupt through request, acknowledge and end-of-interrupt.
- Its configuration registers are memory-mapped behind the system bridge as one more device word window.

Parameters:
- NUM_SRC, 6: number of interrupt sources (fixed mapping: 0 = TC0, 1 = TC1, 2 = external; remaining sources tied 0).
- VEC_W, 3: vector width; must satisfy 2^VEC_W >= NUM_SRC.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- src  in  NUM_SRC  raw interrupt lines
- addr  in  2  word select (bridge address bits [3:2])
- we  in  1  register write enable
- wdata  in  32  register write data
- rdata  out  32  register read data (combinational from addr)
- int_req  out  1  registered interrupt request to CPU
- int_vec  out  VEC_W  registered vector of the request being offered or serviced
- int_ack  in  1  CPU acknowledge, 1-cycle pulse
- busy  out  1  high in REQ or SERVICE

Behaviour:
- Register map (addr):
  - 0 = MASK (rw, bit i = 1 enables source i).
  - 1 = PENDING (read; write-1-to-clear).
  - 2 = MODE (rw, bit i = 1 edge, 0 level).
  - 3 = STATUS/EOI. Read returns {state[1:0] in bits 9:8, int_vec in low bits}; any write is EOI.
  - Unused bits read 0.
- Reset: MASK = 0, PENDING = 0, MODE = 0, src_prev = 0, state = IDLE, int_req = 0, int_vec = 0, busy = 0.
- Edge mode:
  - pending[i] set at the clock edge where src[i] = 1 and src_prev[i] = 0.
  - src_prev is updated every cycle.
- Level mode:
  - pending[i] set every cycle src[i] = 1.
  - A W1C clear is overridden while src stays high.
- Set and W1C clear on the same edge: set wins.
- Masking affects only the request, never pending capture.
- FSM IDLE:
  - If (pending & MASK) != 0, go to REQ.
  - int_vec = lowest set index (index 0 is highest priority); int_req = 1 on the same edge.
- FSM REQ:
  - Hold int_req and int_vec stable until int_ack.
  - Changes to MASK or PENDING do not withdraw or re-prioritise the request.
  - On int_ack: go to SERVICE, int_req = 0, clear pending[int_vec] on the same edge (edge mode only).
- FSM SERVICE:
  - No new request is issued.
  - EOI write: go to IDLE. The earliest next int_req is the edge after IDLE is entered, i.e. 2 edges after EOI.
- Ignored events:
  - EOI written in IDLE or REQ is ignored.
  - int_ack in IDLE or SERVICE is ignored.
- Latency: src rising, sampled at edge k, sets pending at k; int_req is high after edge k+1.
- Reset asserted mid-operation returns to IDLE with all registers cleared on that edge; the outstanding request is dropped.
- Register writes take effect at the clock edge; rdata reflects values after that edge.

Optional Feature:
- Macro INT_CTRL_SYNC_EN.
- Defined: src passes through a 2-flop synchroniser before edge/level detection, adding 2 cycles of latency (int_req high after edge k+3). src_prev is taken from the synchroniser output.
- Undefined: src is used directly, as above.

Decomposition:
- Shared package int_ctrl_pkg holds:
  - register index constants (REG_MASK = 0, REG_PEND = 1, REG_MODE = 2, REG_STAT = 3);
  - the state encoding (IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2);
  - the source index constants (SRC_TC0, SRC_TC1, SRC_EXT).
- One sub-module: int_prio_enc, a combinational lowest-index priority encoder with a valid output.

Test Plan:
- Reset, then MASK = 0x07, MODE = 0x07, pulse src[1] for 1 cycle -> PENDING = 0x02, int_req high 2 edges after the pulse with int_vec = 1; int_ack -> PENDING = 0x00, busy = 1; EOI -> IDLE, int_req stays 0.
- Same-edge rise of src[2] and src[0] -> int_vec = 0. After ack and EOI, int_req re-asserts with int_vec = 2.
- MASK = 0x00, pulse src[0] -> PENDING = 0x01, no int_req. Write MASK = 0x01 -> int_req on the next edge. Write PENDING = 0x01 while in REQ -> request held, int_vec = 0.
- Level mode (MODE = 0), src[1] held high, W1C PENDING = 0x02 -> PENDING reads 0x02. Drop src[1], then W1C -> PENDING = 0x00.
- Assert reset while in SERVICE -> next edge int_req = 0, busy = 0, MASK = PENDING = MODE = 0, STATUS = 0.
- With INT_CTRL_SYNC_EN defined, src[0] rise sampled at edge k -> int_req first high after edge k+3. int_ack in IDLE -> no effect.
